// File: rtl/prio_encoder_rr_pkg.sv
// prio_encoder_rr_pkg: shared definitions for the registered priority encoder.
//   MODE_FIXED / MODE_RR : values of the run-time mode input
//   state_t              : handshake FSM state (EMPTY, FULL)
package prio_encoder_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/prio_encoder_rr_prio_find.sv
// prio_find: combinational highest-set-bit finder.
//   vec_i : request vector
//   idx_o : index of the highest set bit (0 when vec_i is all-zero)
//   any_o : at least one bit of vec_i is set
module prio_find #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        idx_o = '0;
        any_o = |vec_i;
        // Ascending scan: the last hit, i.e. the highest index, wins.
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: registered priority encoder, fixed or round-robin, with
// valid/ready handshake on input and output.
//   clk, rst_n           : clock, asynchronous active-low reset
//   vec, vec_valid       : request vector and its valid
//   vec_ready            : vector is captured this edge when vec_valid is high
//   mode                 : MODE_FIXED (highest index) or MODE_RR, sampled at capture
//   idx, none, idx_valid : registered result (none = captured vector was zero)
//   idx_ready            : consumer accepts the result
module prio_encoder_rr
    import prio_encoder_rr_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] vec,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic             mode,
    output logic [IDX_W-1:0] idx,
    output logic             none,
    output logic             idx_valid,
    input  logic             idx_ready
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W:0]   WidthW  = (IDX_W + 1)'(WIDTH);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             none_q, none_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [IDX_W-1:0]   off;
    logic [2*WIDTH-1:0] vec_dbl;
    logic [WIDTH-1:0]   vec_rot;
    logic [IDX_W-1:0]   rot_idx;
    logic               rot_any;
    logic [IDX_W:0]     win_sum;
    logic [IDX_W-1:0]   win_idx;
    logic               capture;

    // Rotate so that bit ptr lands on the top position: the highest-first
    // finder then searches ptr, ptr-1, ..., 0, WIDTH-1, ..., ptr+1.
    // Fixed mode uses no rotation.
    always_comb begin
        off = '0;
        if (mode == MODE_RR) begin
            off = (ptr_q == LastIdx) ? '0 : ptr_q + IDX_W'(1);
        end
        vec_dbl = {vec, vec};
        vec_rot = vec_dbl[off +: WIDTH];
    end

    prio_find #(
        .WIDTH (WIDTH)
    ) u_prio_find (
        .vec_i (vec_rot),
        .idx_o (rot_idx),
        .any_o (rot_any)
    );

    // Undo the rotation modulo WIDTH (not 2^IDX_W).
    always_comb begin
        win_sum = {1'b0, rot_idx} + {1'b0, off};
        if (win_sum >= WidthW) begin
            win_sum = win_sum - WidthW;
        end
        win_idx = win_sum[IDX_W-1:0];
    end

    assign idx_valid = (state_q == FULL);
    assign vec_ready = !idx_valid || idx_ready;
    assign capture   = vec_valid && vec_ready;
    assign idx       = idx_q;
    assign none      = none_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        none_d  = none_q;
        ptr_d   = ptr_q;
        if (capture) begin
            state_d = FULL;
            idx_d   = rot_any ? win_idx : '0;
            none_d  = !rot_any;
            // Last winner becomes lowest priority; zero vectors leave ptr alone.
            if (mode == MODE_RR && rot_any) begin
                ptr_d = (win_idx == '0) ? LastIdx : win_idx - IDX_W'(1);
            end
        end else if (idx_valid && idx_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            idx_q   <= '0;
            none_q  <= 1'b0;
            ptr_q   <= LastIdx;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            none_q  <= none_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// tb_prio_encoder_rr: directed self-checking bench for prio_encoder_rr, WIDTH = 8.
module tb_prio_encoder_rr;

    localparam int unsigned WIDTH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] vec;
    logic       vec_valid;
    logic       vec_ready;
    logic       mode;
    logic [2:0] idx;
    logic       none;
    logic       idx_valid;
    logic       idx_ready;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    prio_encoder_rr #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vec       (vec),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .mode      (mode),
        .idx       (idx),
        .none      (none),
        .idx_valid (idx_valid),
        .idx_ready (idx_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m, input logic [7:0] v);
        mode      = m;
        vec       = v;
        vec_valid = 1'b1;
        step();
    endtask

    task automatic check_res(input string tag, input int exp_idx, input int exp_none);
        check_eq({tag, ".idx"}, 32'(idx), 32'(exp_idx));
        check_eq({tag, ".none"}, 32'(none), 32'(exp_none));
        check_eq({tag, ".valid"}, 32'(idx_valid), 32'd1);
    endtask

    // Round-robin stream of 8'hFF starting from reset pointer.
    int rr_seq [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

    initial begin
        rst_n     = 1'b0;
        vec       = '0;
        vec_valid = 1'b0;
        mode      = 1'b0;
        idx_ready = 1'b1;
        #2;
        check_eq("rst.valid", 32'(idx_valid), 32'd0);
        check_eq("rst.ready", 32'(vec_ready), 32'd1);
        check_eq("rst.idx", 32'(idx), 32'd0);
        check_eq("rst.none", 32'(none), 32'd0);
        #10;
        rst_n = 1'b1;

        // Fixed mode, highest set bit.
        drive(1'b0, 8'b0010_1100);
        check_res("fixed", 5, 0);
        drive(1'b0, 8'b1000_0001);
        check_res("fixed2", 7, 0);

        // Zero vectors in both modes.
        drive(1'b0, 8'h00);
        check_res("zero_fx", 0, 1);
        drive(1'b1, 8'h00);
        check_res("zero_rr", 0, 1);

        // Round-robin stream; first grant 7 proves ptr untouched so far.
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 8'hFF);
            check_res($sformatf("rr_ff%0d", i), rr_seq[i], 0);
        end
        // ptr = 6 now; single bit 0 found after wrap-free search.
        drive(1'b1, 8'b0000_0001);
        check_res("rr_b0", 0, 0);
        // ptr = 7: both ends set, 7 wins.
        drive(1'b1, 8'b1000_0001);
        check_res("rr_wrap7", 7, 0);
        // ptr = 6: same vector, 0 wins.
        drive(1'b1, 8'b1000_0001);
        check_res("rr_wrap0", 0, 0);

        // Accept without capture empties the register.
        vec_valid = 1'b0;
        step();
        check_eq("drain.valid", 32'(idx_valid), 32'd0);
        check_eq("drain.ready", 32'(vec_ready), 32'd1);

        // Back-pressure. ptr = 7: bit 4 wins, ptr -> 3.
        idx_ready = 1'b0;
        drive(1'b1, 8'b0001_0000);
        check_res("bp_cap", 4, 0);
        for (int i = 0; i < 4; i++) begin
            vec = 8'(8'h11 << i) | 8'h81;
            step();
            check_eq($sformatf("bp_ready%0d", i), 32'(vec_ready), 32'd0);
            check_res($sformatf("bp_hold%0d", i), 4, 0);
        end
        // Release with a new vector: search 3,2,1,0,7,6,5 -> 5, ptr -> 4.
        vec       = 8'b0010_0000;
        idx_ready = 1'b1;
        #1;
        check_eq("bp_rel.ready", 32'(vec_ready), 32'd1);
        check_eq("bp_rel.valid", 32'(idx_valid), 32'd1);
        step();
        check_res("bp_new", 5, 0);

        // ptr = 4: bit 4 wins, ptr -> 3, held FULL.
        drive(1'b1, 8'b0001_0000);
        check_res("pre_rst", 4, 0);

        // Reset mid-operation with a capture pending.
        vec   = 8'hFF;
        rst_n = 1'b0;
        #1;
        check_eq("mrst.valid", 32'(idx_valid), 32'd0);
        check_eq("mrst.idx", 32'(idx), 32'd0);
        check_eq("mrst.none", 32'(none), 32'd0);
        check_eq("mrst.ready", 32'(vec_ready), 32'd1);
        step();
        check_eq("mrst_hold.valid", 32'(idx_valid), 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        check_res("post_rst", 7, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
